gmod2_eeprom: RTL and testbench
===============================

Name: gmod2_eeprom

Overview:
- Responder model of an M93C86-class Microwire serial EEPROM, 1024 x 16 words, driven by the GMOD2 cartridge's bit-banged $DE00 chip-select/clock/data lines.
- Sits beside the cartridge mapper.
- Decodes the serial instruction stream and returns read data on DO. Models write-enable, program busy time and bulk erase/write.
- A host port lets the save/load logic preload and dump contents.

Parameters:
- BUSY_CYCLES, 16000, clk32 cycles DO reports busy after a single-word program (~0.5 ms).
- ADDR_W, 10, word address width (1024 words).

Ports:
- clk32  in  1  system clock.
- reset  in  1  synchronous, active-low.
- ee_cs  in  1  chip select from cartridge, active high.
- ee_sk  in  1  serial clock from cartridge (level, sampled on clk32).
- ee_di  in  1  serial data in.
- ee_do  out  1  serial data out / ready-busy.
- host_addr  in  10  host word address.
- host_din  in  16  host write data.
- host_we  in  1  host write strobe, one word per cycle.
- host_dout  out  16  host read data, 1-cycle latency.
- busy  out  1  program cycle in progress.
- dirty  out  1  set by any serial program; cleared by host_we.

Behaviour:
- Reset (reset=0): state IDLE, write-enable latch = 0 (EWDS), ee_do=1, busy=0, busy counter=0, bit counter=0. dirty and memory contents are preserved.
- SK edge: rising edge = ee_sk high in this cycle and low in the previous one. DI is sampled in the same clk32 cycle. All serial actions occur only on detected rising edges with ee_cs=1.
- ee_cs=0: state returns to IDLE and any partial instruction is discarded. ee_do=1 unless a program cycle is pending (see busy).
- States:
  - IDLE: DI=0 edges ignored. First DI=1 edge is the start bit -> CMD.
  - CMD: shift 12 bits: opcode[1:0] then A[9:0]. Then decode:
    - 10 READ -> RD.
    - 01 WRITE -> WDATA.
    - 11 ERASE -> DONE, pending=erase.
    - 00 with A[9:8]=11 EWEN: latch=1 -> DONE.
    - 00 with A[9:8]=00 EWDS: latch=0 -> DONE.
    - 00 with A[9:8]=10 ERAL -> DONE, pending=eral.
    - 00 with A[9:8]=01 WRAL -> WDATA.
  - RD: ee_do=0 (dummy bit) from the cycle after the A0 edge. Each subsequent edge presents the next data bit MSB first on ee_do, one clk32 after the edge. After D0, the address increments (0x3FF wraps to 0x000) and the next word streams with no dummy bit. Continues until CS low.
  - WDATA: shift 16 bits MSB first -> DONE, pending=write/wral. Extra edges in DONE are ignored.
  - DONE: waits for CS low.
- Program start: on the CS falling edge in DONE with pending set and latch=1.
  - write/erase: memory write (erase writes 0xFFFF) occurs that cycle. busy=1 for BUSY_CYCLES.
  - eral/wral: one word per cycle from 0x000 to 0x3FF. busy lasts max(BUSY_CYCLES, 1024).
  - latch=0: pending is dropped, no write, busy stays 0.
  - CS drop before DONE: no write.
- Busy: while busy and CS=1, ee_do=0, and start bits are ignored (IDLE is held). When the count expires: busy=0, and with CS=1, ee_do=1 (ready).
- dirty: set at each program start. Cleared by host_we.
- Host port:
  - host_dout = mem[host_addr] registered, valid 1 cycle later.
  - host_we writes mem[host_addr] in the same cycle.
  - Same address and same cycle as a serial program: the serial write wins.
- Reset mid-program: busy and counter clear, and any ERAL/WRAL sweep stops at its current address. Words already written stay written.

Test Plan:
- Send EWEN, then WRITE A=0x005 D=0xBEEF, CS low, CS high -> ee_do=0 for BUSY_CYCLES, then 1. Then READ 0x005 -> dummy 0 followed by bits 1011111011101111. dirty=1.
- After EWDS, WRITE A=0x005 D=0x1234 -> busy stays 0, and READ 0x005 still returns 0xBEEF.
- Host preload 0x3FF=0xA5A5, 0x000=0x5A5A; READ 0x3FF for 32 data clocks -> 0xA5A5 then 0x5A5A (wrap).
- EWEN then ERAL -> busy ≥1024 cycles. Host reads of 0x000, 0x200, 0x3FF all = 0xFFFF afterwards.
- CS dropped after 20 of the 29 WRITE edges -> memory unchanged, busy=0. Leading DI=0 clocks before a start bit are ignored and the following command decodes correctly.
- Pull reset low mid-WRAL -> busy=0, ee_do=1, and latch=0 (a following WRITE is ignored). Words before the stop address hold the WRAL data; words after it are unchanged.

Source files
------------

// File: rtl/gmod2_eeprom.sv
// gmod2_eeprom: Microwire responder model of an M93C86-class serial EEPROM
// (1024 x 16). It sits beside the GMOD2 mapper and serves the $DE00
// bit-banged CS/SK/DI/DO lines.
// Ports:
//   clk32            system clock
//   reset            synchronous, active-low
//   ee_cs/ee_sk/ee_di serial chip select, clock level, data in
//   ee_do            serial data out / ready-busy
//   host_addr/host_din/host_we  host preload port (write in same cycle)
//   host_dout        host read data, registered (1-cycle latency)
//   busy             program cycle in progress
//   dirty            set on any serial program, cleared by host_we
module gmod2_eeprom #(
    parameter int BUSY_CYCLES = 16000,
    parameter int ADDR_W      = 10
) (
    input  logic              clk32,
    input  logic              reset,
    input  logic              ee_cs,
    input  logic              ee_sk,
    input  logic              ee_di,
    output logic              ee_do,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_din,
    input  logic              host_we,
    output logic [15:0]       host_dout,
    output logic              busy,
    output logic              dirty
);
    localparam int WORDS       = 1 << ADDR_W;
    localparam int BULK_CYCLES = (BUSY_CYCLES > WORDS) ? BUSY_CYCLES : WORDS;

    typedef enum logic [2:0] {IDLE, CMD, RD, WDATA, DONE} state_t;
    typedef enum logic [2:0] {P_NONE, P_WRITE, P_ERASE, P_ERAL, P_WRAL} pend_t;

    logic [15:0] mem [0:WORDS-1];

    state_t            state, state_n;
    pend_t             pend, pend_n;
    logic [3:0]        cnt, cnt_n;
    logic [15:0]       shreg, shreg_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [15:0]       wdata, wdata_n;
    logic              wen, wen_n;
    logic              do_q, do_n;
    logic [31:0]       busy_cnt, busy_cnt_n;
    logic              sweep, sweep_n;
    logic [ADDR_W-1:0] sweep_addr, sweep_addr_n;
    logic              dirty_n;
    logic [15:0]       rd_word;
    logic              sk_q;
    logic              sk_rise;
    logic [ADDR_W+1:0] full;
    logic [15:0]       fill;
    logic              ser_we;
    logic [ADDR_W-1:0] ser_addr;
    logic [15:0]       ser_data;

    assign sk_rise = ee_sk & ~sk_q;
    assign busy    = (busy_cnt != '0);
    // Busy reports 0 regardless of CS; otherwise idle bus reads as 1.
    assign ee_do   = busy ? 1'b0 : (ee_cs ? do_q : 1'b1);
    // Complete command word including the bit arriving on this edge.
    assign full    = {shreg[ADDR_W:0], ee_di};
    assign fill    = (pend == P_ERASE || pend == P_ERAL) ? 16'hFFFF : wdata;

    always_comb begin
        state_n      = state;
        pend_n       = pend;
        cnt_n        = cnt;
        shreg_n      = shreg;
        addr_n       = addr;
        wdata_n      = wdata;
        wen_n        = wen;
        do_n         = do_q;
        busy_cnt_n   = busy ? busy_cnt - 32'd1 : '0;
        sweep_n      = sweep;
        sweep_addr_n = sweep_addr;
        dirty_n      = host_we ? 1'b0 : dirty;
        ser_we       = 1'b0;
        ser_addr     = addr;
        ser_data     = wdata;

        if (sweep && reset) begin
            ser_we       = 1'b1;
            ser_addr     = sweep_addr;
            sweep_addr_n = sweep_addr + 1'b1;
            if (sweep_addr == '1)
                sweep_n = 1'b0;
        end

        if (!ee_cs) begin
            state_n = IDLE;
            do_n    = 1'b1;
            pend_n  = P_NONE;
            // Falling CS edge out of DONE launches the program cycle.
            if (reset && state == DONE && pend != P_NONE && wen) begin
                dirty_n = 1'b1;
                wdata_n = fill;
                if (pend == P_WRITE || pend == P_ERASE) begin
                    ser_we     = 1'b1;
                    ser_addr   = addr;
                    ser_data   = fill;
                    busy_cnt_n = 32'(BUSY_CYCLES);
                end else begin
                    sweep_n      = 1'b1;
                    sweep_addr_n = '0;
                    busy_cnt_n   = 32'(BULK_CYCLES);
                end
            end
        end else if (sk_rise) begin
            case (state)
                IDLE: begin
                    if (ee_di && !busy) begin
                        state_n = CMD;
                        cnt_n   = '0;
                    end
                end
                CMD: begin
                    shreg_n = {shreg[14:0], ee_di};
                    cnt_n   = cnt + 4'd1;
                    if (cnt == 4'(ADDR_W + 1)) begin
                        addr_n = full[ADDR_W-1:0];
                        cnt_n  = '0;
                        case (full[ADDR_W+1:ADDR_W])
                            2'b10: begin state_n = RD; do_n = 1'b0; end
                            2'b01: begin state_n = WDATA; pend_n = P_WRITE; end
                            2'b11: begin state_n = DONE; pend_n = P_ERASE; end
                            default: begin
                                case (full[ADDR_W-1:ADDR_W-2])
                                    2'b11:   begin wen_n = 1'b1; state_n = DONE; end
                                    2'b00:   begin wen_n = 1'b0; state_n = DONE; end
                                    2'b10:   begin state_n = DONE; pend_n = P_ERAL; end
                                    default: begin state_n = WDATA; pend_n = P_WRAL; end
                                endcase
                            end
                        endcase
                    end
                end
                RD: begin
                    do_n  = rd_word[~cnt];
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd15)
                        addr_n = addr + 1'b1;
                end
                WDATA: begin
                    shreg_n = {shreg[14:0], ee_di};
                    cnt_n   = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        wdata_n = {shreg[14:0], ee_di};
                        state_n = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk32) begin
        if (!reset) begin
            state    <= IDLE;
            pend     <= P_NONE;
            cnt      <= '0;
            wen      <= 1'b0;
            do_q     <= 1'b1;
            busy_cnt <= '0;
            sweep    <= 1'b0;
        end else begin
            state    <= state_n;
            pend     <= pend_n;
            cnt      <= cnt_n;
            wen      <= wen_n;
            do_q     <= do_n;
            busy_cnt <= busy_cnt_n;
            sweep    <= sweep_n;
        end
        shreg      <= shreg_n;
        addr       <= addr_n;
        wdata      <= wdata_n;
        sweep_addr <= sweep_addr_n;
        dirty      <= dirty_n;
        sk_q       <= ee_sk;
    end

    // Serial write is issued last so it wins a same-address collision.
    always_ff @(posedge clk32) begin
        if (host_we)
            mem[host_addr] <= host_din;
        if (ser_we)
            mem[ser_addr] <= ser_data;
        host_dout <= mem[host_addr];
        rd_word   <= mem[addr];
    end
endmodule

// File: tb/tb_gmod2_eeprom.sv
module tb_gmod2_eeprom;
    localparam int BUSY = 40;

    logic        clk32 = 1'b0;
    logic        reset = 1'b0;
    logic        ee_cs = 1'b0;
    logic        ee_sk = 1'b0;
    logic        ee_di = 1'b0;
    logic        ee_do;
    logic [9:0]  host_addr = '0;
    logic [15:0] host_din = '0;
    logic        host_we = 1'b0;
    logic [15:0] host_dout;
    logic        busy;
    logic        dirty;

    int errors = 0;
    int checks = 0;

    gmod2_eeprom #(.BUSY_CYCLES(BUSY), .ADDR_W(10)) dut (
        .clk32(clk32), .reset(reset), .ee_cs(ee_cs), .ee_sk(ee_sk), .ee_di(ee_di),
        .ee_do(ee_do), .host_addr(host_addr), .host_din(host_din), .host_we(host_we),
        .host_dout(host_dout), .busy(busy), .dirty(dirty)
    );

    always #5 clk32 = ~clk32;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic sk_bit(input logic b);
        ee_di = b;
        ee_sk = 1'b1;
        tick(); tick();
        ee_sk = 1'b0;
        tick(); tick();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [9:0] a, input int nbits);
        logic [12:0] w;
        w = {1'b1, op, a};
        ee_cs = 1'b1;
        tick();
        for (int i = 12; i > 12 - nbits && i >= 0; i--) sk_bit(w[i]);
    endtask

    task automatic send_data(input logic [15:0] d, input int nbits);
        for (int i = 15; i > 15 - nbits && i >= 0; i--) sk_bit(d[i]);
    endtask

    task automatic cs_low();
        ee_cs = 1'b0;
        tick();
    endtask

    // Counts cycles with ee_do low while CS is held high.
    task automatic wait_busy(output int n);
        ee_cs = 1'b1;
        n = 0;
        while (ee_do === 1'b0 && n < 5000) begin
            n++;
            tick();
        end
        ee_cs = 1'b0;
        tick();
    endtask

    task automatic read_word(output logic [15:0] w);
        w = '0;
        for (int i = 0; i < 16; i++) begin
            sk_bit(1'b0);
            w = {w[14:0], ee_do};
        end
    endtask

    task automatic host_wr(input logic [9:0] a, input logic [15:0] d);
        host_addr = a;
        host_din  = d;
        host_we   = 1'b1;
        tick();
        host_we   = 1'b0;
    endtask

    task automatic host_chk(input string tag, input logic [9:0] a, input logic [15:0] exp);
        host_addr = a;
        tick();
        check(tag, {16'h0, host_dout}, {16'h0, exp});
    endtask

    task automatic write_word(input logic [9:0] a, input logic [15:0] d);
        send_cmd(2'b01, a, 13);
        send_data(d, 16);
        cs_low();
    endtask

    initial begin
        int n;
        logic [15:0] w;

        tick(); tick();
        check("reset_do", {31'h0, ee_do}, 32'h1);
        check("reset_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        tick();
        host_wr(10'h005, 16'h0000);
        tick();
        check("dirty_clear", {31'h0, dirty}, 32'h0);

        // EWEN then WRITE 0x005 = 0xBEEF
        send_cmd(2'b00, 10'h300, 13);
        cs_low();
        check("ewen_nobusy", {31'h0, busy}, 32'h0);
        write_word(10'h005, 16'hBEEF);
        check("write_busy", {31'h0, busy}, 32'h1);
        wait_busy(n);
        check("write_busy_len", n, BUSY);
        ee_cs = 1'b1;
        tick();
        check("ready_after", {31'h0, ee_do}, 32'h1);
        check("dirty_set", {31'h0, dirty}, 32'h1);
        cs_low();

        send_cmd(2'b10, 10'h005, 13);
        check("rd_dummy", {31'h0, ee_do}, 32'h0);
        read_word(w);
        check("rd_beef", {16'h0, w}, 32'h0000BEEF);
        cs_low();
        host_chk("host_beef", 10'h005, 16'hBEEF);

        // EWDS then WRITE must be ignored
        send_cmd(2'b00, 10'h000, 13);
        cs_low();
        write_word(10'h005, 16'h1234);
        check("ewds_nobusy", {31'h0, busy}, 32'h0);
        send_cmd(2'b10, 10'h005, 13);
        read_word(w);
        check("ewds_keep", {16'h0, w}, 32'h0000BEEF);
        cs_low();

        // sequential read wrap
        host_wr(10'h3FF, 16'hA5A5);
        host_wr(10'h000, 16'h5A5A);
        send_cmd(2'b10, 10'h3FF, 13);
        read_word(w);
        check("wrap_w0", {16'h0, w}, 32'h0000A5A5);
        read_word(w);
        check("wrap_w1", {16'h0, w}, 32'h00005A5A);
        cs_low();

        // EWEN, ERAL
        send_cmd(2'b00, 10'h300, 13);
        cs_low();
        send_cmd(2'b00, 10'h200, 13);
        cs_low();
        wait_busy(n);
        check("eral_busy_ge1024", {31'h0, (n >= 1024 && n < 5000)}, 32'h1);
        host_chk("eral_000", 10'h000, 16'hFFFF);
        host_chk("eral_200", 10'h200, 16'hFFFF);
        host_chk("eral_3ff", 10'h3FF, 16'hFFFF);

        // truncated WRITE: 20 of 29 edges
        host_wr(10'h010, 16'h1111);
        send_cmd(2'b01, 10'h010, 13);
        send_data(16'h2222, 7);
        cs_low();
        check("trunc_nobusy", {31'h0, busy}, 32'h0);
        host_chk("trunc_mem", 10'h010, 16'h1111);

        // leading DI=0 clocks before the start bit
        ee_cs = 1'b1;
        tick();
        sk_bit(1'b0); sk_bit(1'b0); sk_bit(1'b0);
        send_cmd(2'b01, 10'h011, 13);
        send_data(16'h3333, 16);
        cs_low();
        wait_busy(n);
        check("lead0_busy", n, BUSY);
        host_chk("lead0_mem", 10'h011, 16'h3333);

        // WRAL interrupted by reset
        host_wr(10'h3F0, 16'h7777);
        send_cmd(2'b00, 10'h100, 13);
        send_data(16'hC3C3, 16);
        cs_low();
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        ee_cs = 1'b1;
        tick();
        check("wral_rst_busy", {31'h0, busy}, 32'h0);
        check("wral_rst_do", {31'h0, ee_do}, 32'h1);
        cs_low();
        host_chk("wral_001", 10'h001, 16'hC3C3);
        host_chk("wral_050", 10'h050, 16'hC3C3);
        host_chk("wral_200", 10'h200, 16'hFFFF);
        host_chk("wral_3f0", 10'h3F0, 16'h7777);

        // latch cleared by reset: WRITE ignored
        write_word(10'h3F0, 16'h0000);
        check("latch_nobusy", {31'h0, busy}, 32'h0);
        host_chk("latch_mem", 10'h3F0, 16'h7777);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
